// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the sync FIFO write port.
// One requester owns the port at a time and may stream up to MAX_BURST
// beats before the grant is re-arbitrated. Handover is zero-bubble.
// Optional per-requester accepted-beat counters: FIFO_WR_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner, waiting for any req_valid
// OWN   | owner_q holds the write port; beats accepted when FIFO not full
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_WIDTH  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [WIDTH-1:0]              fifo_wdata,
    output logic [ID_WIDTH-1:0]           gnt_id,
    output logic                          busy,
    input  logic                          stat_clr,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_cnt
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [ID_WIDTH-1:0] last_gnt_q, last_gnt_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic [7:0]          burst_inc;
    logic [ID_WIDTH-1:0] pick_base, pick_id, cand;
    logic                own_valid;
    logic [WIDTH-1:0]    own_data;
    logic                any_valid;
    logic                release_own;

    assign any_valid = |req_valid;

    // Select the current owner's valid and data.
    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_WIDTH'(i)) begin
                own_valid = req_valid[i];
                own_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pick: first valid requester after the base, base itself last.
    // In OWN the base is the releasing owner, which becomes last_gnt.
    always_comb begin
        pick_base = (state_q == OWN) ? owner_q : last_gnt_q;
        pick_id   = pick_base;
        cand      = pick_base;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_WIDTH'((int'(pick_base) + k) % NUM_REQ);
            if (req_valid[cand]) pick_id = cand;
        end
    end

    // Outputs are decoded from registered state; they clear asynchronously with reset.
    assign busy       = (state_q == OWN);
    assign gnt_id     = busy ? owner_q : '0;
    assign fifo_wr_en = busy & own_valid & ~fifo_full;
    assign fifo_wdata = busy ? own_data : '0;

    // Ready is granted to the owner regardless of its valid, masked by full.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = busy && (owner_q == ID_WIDTH'(i)) && !fifo_full;
        end
    end

    // Next-state: grant, burst counting and release / zero-bubble regrant.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        burst_inc   = burst_cnt_q + 8'd1;
        release_own = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d     = OWN;
                    owner_d     = pick_id;
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                if (fifo_wr_en) burst_cnt_d = burst_inc;
                release_own = !own_valid || (fifo_wr_en && (burst_inc == 8'(MAX_BURST)));
                if (release_own) begin
                    last_gnt_d  = owner_q;
                    burst_cnt_d = '0;
                    if (any_valid) owner_d = pick_id;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_gnt_q  <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] stat_q [NUM_REQ];

    // Saturating accepted-beat counters; clear wins over a same-cycle beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (fifo_wr_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((owner_q == ID_WIDTH'(i)) && (stat_q[i] != '1))
                    stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = stat_q[i];
    end
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: table-driven per-cycle vectors plus
// hand-written sequences for async reset mid-burst and statistics.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        stat_clr;
    logic [15:0] stat_cnt;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef FIFO_WR_ARB_STATS_EN
    localparam logic [15:0] EXP_STAT10 = 16'h000A;
    localparam logic [15:0] EXP_STATSAT = 16'h000F;
`else
    localparam logic [15:0] EXP_STAT10 = 16'h0000;
    localparam logic [15:0] EXP_STATSAT = 16'h0000;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ(4), .WIDTH(8), .MAX_BURST(4), .ID_WIDTH(2), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
        .gnt_id(gnt_id), .busy(busy),
        .stat_clr(stat_clr), .stat_cnt(stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [3:0]  valid;
        logic        full;
        logic [31:0] data;
        logic        exp_wr;
        logic [7:0]  exp_wdata;
        logic [1:0]  exp_gnt;
        logic        exp_busy;
        logic [3:0]  exp_ready;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [3:0] valid, logic full, logic [31:0] data,
                                logic wr, logic [7:0] wdata, logic [1:0] gnt,
                                logic bsy, logic [3:0] rdy, logic rst);
        vec_t v;
        v.rst_before = rst;
        v.valid = valid; v.full = full; v.data = data;
        v.exp_wr = wr; v.exp_wdata = wdata; v.exp_gnt = gnt;
        v.exp_busy = bsy; v.exp_ready = rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; req_valid = '0; fifo_full = 1'b0; stat_clr = 1'b0;
        #1;
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset wr_en", {31'b0, fifo_wr_en}, 32'h0);
        chk("reset ready", {28'b0, req_ready}, 32'h0);
        chk("reset gnt_id", {30'b0, gnt_id}, 32'h0);
        chk("reset wdata", {24'b0, fifo_wdata}, 32'h0);
        chk("reset stat_cnt", {16'b0, stat_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        if (v.rst_before) do_reset();
        @(negedge clk);
        req_valid = v.valid; fifo_full = v.full; req_data = v.data;
        #1;
        chk({tag, " wr_en"},  {31'b0, fifo_wr_en}, {31'b0, v.exp_wr});
        chk({tag, " wdata"},  {24'b0, fifo_wdata}, {24'b0, v.exp_wdata});
        chk({tag, " gnt_id"}, {30'b0, gnt_id},     {30'b0, v.exp_gnt});
        chk({tag, " busy"},   {31'b0, busy},       {31'b0, v.exp_busy});
        chk({tag, " ready"},  {28'b0, req_ready},  {28'b0, v.exp_ready});
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0; stat_clr = 1'b0;

        // Single requester, 6 beats A0..A5: zero-bubble regrant to req0 after 4.
        vq.push_back(mk(4'b0001, 0, 32'h000000A0, 0, 8'h00, 0, 0, 4'b0000, 1));
        for (int b = 0; b < 6; b++)
            vq.push_back(mk(4'b0001, 0, 32'h000000A0 + b, 1, 8'hA0 + 8'(b), 0, 1, 4'b0001, 0));
        vq.push_back(mk(4'b0000, 0, 32'h0, 0, 8'h00, 0, 1, 4'b0001, 0));
        vq.push_back(mk(4'b0000, 0, 32'h0, 0, 8'h00, 0, 0, 4'b0000, 0));

        // All four valid: owners 0,1,2,3,0 in 4-beat bursts, no idle gap.
        vq.push_back(mk(4'b1111, 0, 32'h40302010, 0, 8'h00, 0, 0, 4'b0000, 1));
        for (int o = 0; o < 4; o++)
            for (int b = 0; b < 4; b++)
                vq.push_back(mk(4'b1111, 0, 32'h40302010, 1, 8'h10 * 8'(o + 1), 2'(o), 1,
                                4'b0001 << o, 0));
        vq.push_back(mk(4'b1111, 0, 32'h40302010, 1, 8'h10, 0, 1, 4'b0001, 0));
        vq.push_back(mk(4'b0000, 0, 32'h40302010, 0, 8'h10, 0, 1, 4'b0001, 0));
        vq.push_back(mk(4'b0000, 0, 32'h40302010, 0, 8'h00, 0, 0, 4'b0000, 0));

        // Owner 2 stalled by fifo_full for 3 cycles after 2 beats, then finishes.
        vq.push_back(mk(4'b1100, 0, 32'h44332211, 0, 8'h00, 0, 0, 4'b0000, 1));
        vq.push_back(mk(4'b1100, 0, 32'h44332211, 1, 8'h33, 2, 1, 4'b0100, 0));
        vq.push_back(mk(4'b1100, 0, 32'h44332211, 1, 8'h33, 2, 1, 4'b0100, 0));
        vq.push_back(mk(4'b1100, 1, 32'h44332211, 0, 8'h33, 2, 1, 4'b0000, 0));
        vq.push_back(mk(4'b1100, 1, 32'h44332211, 0, 8'h33, 2, 1, 4'b0000, 0));
        vq.push_back(mk(4'b1100, 1, 32'h44332211, 0, 8'h33, 2, 1, 4'b0000, 0));
        vq.push_back(mk(4'b1100, 0, 32'h44332211, 1, 8'h33, 2, 1, 4'b0100, 0));
        vq.push_back(mk(4'b1100, 0, 32'h44332211, 1, 8'h33, 2, 1, 4'b0100, 0));
        vq.push_back(mk(4'b1100, 0, 32'h44332211, 1, 8'h44, 3, 1, 4'b1000, 0));
        vq.push_back(mk(4'b0000, 0, 32'h44332211, 0, 8'h44, 3, 1, 4'b1000, 0));
        vq.push_back(mk(4'b0000, 0, 32'h44332211, 0, 8'h00, 0, 0, 4'b0000, 0));

        // Owner 1 drops valid after 1 beat; req3 served next, req1 after req3's burst.
        vq.push_back(mk(4'b1010, 0, 32'h44332211, 0, 8'h00, 0, 0, 4'b0000, 1));
        vq.push_back(mk(4'b1010, 0, 32'h44332211, 1, 8'h22, 1, 1, 4'b0010, 0));
        vq.push_back(mk(4'b1000, 0, 32'h44332211, 0, 8'h22, 1, 1, 4'b0010, 0));
        for (int b = 0; b < 4; b++)
            vq.push_back(mk(4'b1010, 0, 32'h44332211, 1, 8'h44, 3, 1, 4'b1000, 0));
        vq.push_back(mk(4'b1010, 0, 32'h44332211, 1, 8'h22, 1, 1, 4'b0010, 0));
        vq.push_back(mk(4'b0000, 0, 32'h44332211, 0, 8'h22, 1, 1, 4'b0010, 0));
        vq.push_back(mk(4'b0000, 0, 32'h44332211, 0, 8'h00, 0, 0, 4'b0000, 0));

        for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

        // Async reset mid-burst of req0, then req0/req1 both valid: req0 first.
        apply(mk(4'b0001, 0, 32'h0000C1C0, 0, 8'h00, 0, 0, 4'b0000, 1), "rstmid0");
        apply(mk(4'b0001, 0, 32'h0000C1C0, 1, 8'hC0, 0, 1, 4'b0001, 0), "rstmid1");
        apply(mk(4'b0001, 0, 32'h0000C1C0, 1, 8'hC0, 0, 1, 4'b0001, 0), "rstmid2");
        #2;
        reset = 1'b0;
        #1;
        chk("async rst busy", {31'b0, busy}, 32'h0);
        chk("async rst wr_en", {31'b0, fifo_wr_en}, 32'h0);
        chk("async rst ready", {28'b0, req_ready}, 32'h0);
        chk("async rst gnt_id", {30'b0, gnt_id}, 32'h0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        apply(mk(4'b0011, 0, 32'h0000C1C0, 0, 8'h00, 0, 0, 4'b0000, 0), "post0");
        apply(mk(4'b0011, 0, 32'h0000C1C0, 1, 8'hC0, 0, 1, 4'b0001, 0), "post1");
        apply(mk(4'b0010, 0, 32'h0000C1C0, 0, 8'hC0, 0, 1, 4'b0001, 0), "post2");
        apply(mk(4'b0010, 0, 32'h0000C1C0, 1, 8'hC1, 1, 1, 4'b0010, 0), "post3");
        apply(mk(4'b0000, 0, 32'h0000C1C0, 0, 8'hC1, 1, 1, 4'b0010, 0), "post4");
        apply(mk(4'b0000, 0, 32'h0000C1C0, 0, 8'h00, 0, 0, 4'b0000, 0), "post5");

        // Statistics: 20 beats from req0 saturate a 4-bit counter; clear wins.
        do_reset();
        req_valid = 4'b0001; req_data = 32'h000000E0;
        repeat (11) @(negedge clk);
        #1;
        chk("stat after 10 beats", {16'b0, stat_cnt}, {16'b0, EXP_STAT10});
        repeat (10) @(negedge clk);
        req_valid = '0;
        #1;
        chk("stat saturated", {16'b0, stat_cnt}, {16'b0, EXP_STATSAT});
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        chk("stat cleared", {16'b0, stat_cnt}, 32'h0);
        req_valid = 4'b0001;
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0; req_valid = '0;
        #1;
        chk("stat clr beats inc", {16'b0, stat_cnt}, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
